// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared constants for the EX-stage execute unit.
//   - default widths (datapath, op select, writeback tag)
//   - base ALU op codes (4 bits, alu_op[4] = 0)
//   - multiply/divide op codes (alu_op[4] = 1)
//   - control state enum
package alu_mdu_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int ALU_OP_WIDTH = 5;
    localparam int TAG_W_DEF    = 5;

    localparam logic [3:0] ALU_OP_ADD  = 4'h0;
    localparam logic [3:0] ALU_OP_SUB  = 4'h1;
    localparam logic [3:0] ALU_OP_SLL  = 4'h2;
    localparam logic [3:0] ALU_OP_SRL  = 4'h3;
    localparam logic [3:0] ALU_OP_SRA  = 4'h4;
    localparam logic [3:0] ALU_OP_XOR  = 4'h5;
    localparam logic [3:0] ALU_OP_OR   = 4'h6;
    localparam logic [3:0] ALU_OP_AND  = 4'h7;
    localparam logic [3:0] ALU_OP_SEQ  = 4'h8;
    localparam logic [3:0] ALU_OP_SNE  = 4'h9;
    localparam logic [3:0] ALU_OP_SLT  = 4'hA;
    localparam logic [3:0] ALU_OP_SGE  = 4'hB;
    localparam logic [3:0] ALU_OP_SLTU = 4'hC;
    localparam logic [3:0] ALU_OP_SGEU = 4'hD;

    // Low three bits of the M codes are decoded directly by the datapath:
    // bit 2 = divide, and for divide bit 1 = remainder, bit 0 = unsigned.
    localparam logic [4:0] MDU_OP_MUL    = 5'h10;
    localparam logic [4:0] MDU_OP_MULH   = 5'h11;
    localparam logic [4:0] MDU_OP_MULHSU = 5'h12;
    localparam logic [4:0] MDU_OP_MULHU  = 5'h13;
    localparam logic [4:0] MDU_OP_DIV    = 5'h14;
    localparam logic [4:0] MDU_OP_DIVU   = 5'h15;
    localparam logic [4:0] MDU_OP_REM    = 5'h16;
    localparam logic [4:0] MDU_OP_REMU   = 5'h17;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/result handshake bundle of the execute unit.
//   request : in_valid, in_ready, a, b, alu_op, in_tag
//   result  : out_valid, out_ready, out, out_tag
//   master  = pipeline side, slave = execute unit
interface alu_mdu_if
    import alu_mdu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int OP_WIDTH = ALU_OP_WIDTH,
    parameter int TAG_W    = TAG_W_DEF
);
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [OP_WIDTH-1:0] alu_op;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out;
    logic [TAG_W-1:0]    out_tag;

    modport master (
        output in_valid, a, b, alu_op, in_tag, out_ready,
        input  in_ready, out_valid, out, out_tag
    );

    modport slave (
        input  in_valid, a, b, alu_op, in_tag, out_ready,
        output in_ready, out_valid, out, out_tag
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// alu_mdu_iter: serial multiply/divide core, one bit per cycle on magnitudes.
//   clk, rst_n       : clock, synchronous active-low reset
//   clear            : abort any operation in flight
//   start            : load operands and begin XLEN iterations
//   op[2:0]          : low bits of the M op code
//   mag_a, mag_b     : operand magnitudes
//   neg_res, neg_rem : negate product/quotient, negate remainder
//   done             : one-cycle pulse, result valid
//   result           : signed-corrected result selected by op
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    input  logic            neg_res,
    input  logic            neg_rem,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN);

    // acc holds {product_hi, multiplier/product_lo} or {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q, done_q;
    logic [2:0]        op_q;
    logic              neg_res_q, neg_rem_q;

    logic [XLEN:0]     mul_sum, div_diff;
    logic [2*XLEN:0]   div_shift;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, 1'b0};
        div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opb_q};
        if (op_q[2]) begin
            // restoring step: keep the shifted remainder when the trial subtract borrows
            if (div_diff[XLEN]) acc_d = div_shift[2*XLEN-1:0];
            else                acc_d = {div_diff[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
        end else begin
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (op_q[2])                result = op_q[1] ? rem : quot;
        else if (op_q[1:0] == 2'b00) result = prod[XLEN-1:0];
        else                        result = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                run_q <= 1'b1;
                cnt_q <= CNT_W'(XLEN-1);
            end else if (run_q) begin
                if (cnt_q == '0) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            acc_q     <= {{XLEN{1'b0}}, mag_a};
            opb_q     <= mag_b;
            op_q      <= op;
            neg_res_q <= neg_res;
            neg_rem_q <= neg_rem;
        end else if (run_q) begin
            acc_q <= acc_d;
        end
    end

    assign done = done_q;
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: handshaked EX-stage execute unit (base ALU + serial mul/div).
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : abort in-flight op and drop the held result
//   bus        : request/result handshake (slave side)
//   busy       : iterative op in progress
//
//   state | meaning
//   IDLE  | accepting requests when the output register is free
//   BUSY  | serial mul/div running, requests blocked
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int OP_WIDTH = ALU_OP_WIDTH,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int SHAMT_W  = $clog2(XLEN)
)
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    alu_mdu_if.slave bus,
    output logic     busy
);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q, state_d;
    logic             accept, is_m, is_div, m_unused, div_zero, div_ovf, m_iter;
    logic             a_signed, b_signed, a_neg, b_neg, iter_done;
    logic [XLEN-1:0]  base_res, fast_res, iter_res, mag_a, mag_b;
    logic [SHAMT_W-1:0] shamt;
    logic [TAG_W-1:0] tag_q;

    assign bus.in_ready = rst_n && (state_q != BUSY) && (!bus.out_valid || bus.out_ready) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state_q == BUSY);
    assign shamt        = bus.b[SHAMT_W-1:0];
    assign is_m         = bus.alu_op[4];

    always_comb begin
        base_res = '0;
        case (bus.alu_op[3:0])
            ALU_OP_ADD:  base_res = bus.a + bus.b;
            ALU_OP_SUB:  base_res = bus.a - bus.b;
            ALU_OP_SLL:  base_res = bus.a << shamt;
            ALU_OP_SRL:  base_res = bus.a >> shamt;
            ALU_OP_SRA:  base_res = $unsigned($signed(bus.a) >>> shamt);
            ALU_OP_XOR:  base_res = bus.a ^ bus.b;
            ALU_OP_OR:   base_res = bus.a | bus.b;
            ALU_OP_AND:  base_res = bus.a & bus.b;
            ALU_OP_SEQ:  base_res = XLEN'(bus.a == bus.b);
            ALU_OP_SNE:  base_res = XLEN'(bus.a != bus.b);
            ALU_OP_SLT:  base_res = XLEN'($signed(bus.a) < $signed(bus.b));
            ALU_OP_SGE:  base_res = XLEN'($signed(bus.a) >= $signed(bus.b));
            ALU_OP_SLTU: base_res = XLEN'(bus.a < bus.b);
            ALU_OP_SGEU: base_res = XLEN'(bus.a >= bus.b);
            default:     base_res = '0;
        endcase
    end

    // M decode: divide-by-zero, signed overflow and unused codes finish in one cycle
    always_comb begin
        m_unused = is_m && bus.alu_op[3];
        is_div   = is_m && (bus.alu_op[3:2] == 2'b01);
        if (bus.alu_op[2]) begin
            a_signed = !bus.alu_op[0];
            b_signed = !bus.alu_op[0];
        end else begin
            a_signed = (bus.alu_op[1:0] != 2'b11);
            b_signed = !bus.alu_op[1];
        end
        a_neg    = a_signed && bus.a[XLEN-1];
        b_neg    = b_signed && bus.b[XLEN-1];
        mag_a    = a_neg ? -bus.a : bus.a;
        mag_b    = b_neg ? -bus.b : bus.b;
        div_zero = is_div && (bus.b == '0);
        div_ovf  = is_div && !bus.alu_op[0] && (bus.a == MIN_VAL) && (bus.b == '1);
        m_iter   = is_m && !m_unused && !div_zero && !div_ovf;

        fast_res = '0;
        if (!is_m)         fast_res = base_res;
        else if (div_zero) fast_res = bus.alu_op[1] ? bus.a : '1;
        else if (div_ovf)  fast_res = bus.alu_op[1] ? '0 : MIN_VAL;
    end

    alu_mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .start   (accept && m_iter),
        .op      (bus.alu_op[2:0]),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .neg_res (a_neg ^ b_neg),
        .neg_rem (a_neg),
        .done    (iter_done),
        .result  (iter_res)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && m_iter) state_d = BUSY;
            BUSY:    if (iter_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // The output register is always free when BUSY completes: in_ready
    // required it at accept, so completion never waits on out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.out_tag   <= '0;
            tag_q         <= '0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept && !m_iter) begin
            bus.out_valid <= 1'b1;
            bus.out       <= fast_res;
            bus.out_tag   <= bus.in_tag;
        end else if (state_q == BUSY && iter_done) begin
            bus.out_valid <= 1'b1;
            bus.out       <= iter_res;
            bus.out_tag   <= tag_q;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
        if (rst_n && accept && m_iter) tag_q <= bus.in_tag;
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked execute unit that replaces the purely combinational ALU in the EX stage.
- Keeps all base integer ops with a registered one-cycle result.
- Adds the RV M-extension multiply/divide ops on a serial iterative datapath.
- Carries a writeback tag so the pipeline can retire results out of a stall.

Parameters:
- XLEN, 32, datapath width (≥8, power of two).
- OP_WIDTH, 5, width of alu_op. Bit 4 = 1 selects mul/div; bits 3:0 keep the existing `ALU_OP_* encodings.
- TAG_W, 5, width of the pass-through tag (rd index).
- SHAMT_W, $clog2(XLEN), shift-amount width taken from b[SHAMT_W-1:0].

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous abort of the in-flight op and held result.
- in_valid  in  1  request valid.
- in_ready  out  1  unit accepts a request this cycle.
- a  in  XLEN  operand A (rs1).
- b  in  XLEN  operand B (rs2/imm).
- alu_op  in  OP_WIDTH  operation select.
- in_tag  in  TAG_W  tag captured with the request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- out  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; out_valid=0, out=0, out_tag=0, busy=0.
  - in_ready=0 while rst_n=0.
- Accept: a request transfers when in_valid && in_ready.
- in_ready = rst_n && state!=BUSY && (!out_valid || out_ready) && !flush.
- Output register:
  - Holds out/out_tag stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads the same cycle.
- Base ops (alu_op[4]=0): ADD, SUB, SLL, SRL, SRA, XOR, OR, AND, SEQ, SNE, SLT, SGE, SLTU, SGEU.
  - Result registered; accepted at edge N, out_valid at N+1.
  - Back-to-back throughput is 1/cycle when out_ready=1.
  - Compare results are zero-extended to XLEN (bit 0 = result).
  - Shifts use b[SHAMT_W-1:0] only; SRA sign-fills.
  - Undefined base codes return 0 with out_valid.
- M ops (alu_op[4]=1): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Multiply: shift-add on operand magnitudes, one bit per cycle, XLEN iterations, 2*XLEN accumulator, negated at the end if signs differ.
    - MUL returns the low half; the others return the high half.
    - MULHSU treats a as signed and b as unsigned.
  - Divide: restoring, one quotient bit per cycle, XLEN iterations, on magnitudes.
    - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Latency: accepted at N, out_valid at N+XLEN+1 (N+33 for XLEN=32).
- Special cases, resolved in one cycle (out_valid at N+1, no BUSY):
  - b==0: DIV/DIVU → all-ones; REM/REMU → a.
  - Signed overflow (a==MIN, b==-1): DIV → MIN; REM → 0.
- State machine:
  - IDLE→BUSY on accepting a non-special M op.
  - BUSY counts an iteration counter from XLEN-1 down to 0; at 0 it loads the output register and goes to IDLE.
  - BUSY never stalls on out_ready, because in_ready already guaranteed the output register was free at accept.
- busy = (state==BUSY).
- flush:
  - Next edge: state=IDLE, out_valid=0, counter cleared.
  - A request presented with flush is not accepted.
  - flush has priority over completion in the same cycle.
- rst_n low mid-operation: same effect as flush, plus out/out_tag cleared.
- Unused alu_op codes with bit 4 set return 0 in one cycle.

Decomposition:
- `XLEN, `ALU_OP_WIDTH, all `ALU_OP_* codes, new `MDU_OP_* codes (bit 4 set), and the state enum IDLE/BUSY go in the shared constants.vh package.
- Sub-module mdu_iter holds the serial multiply/divide core:
  - Inputs: start, op, magnitudes, sign flags.
  - Outputs: done, result.
  - Top level owns the handshake, output register, base ALU and special-case detection.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 then SLTU a=1, b=0xFFFFFFFF on consecutive cycles, out_ready=1 → out=0x80000000 at N+1, then 0x00000001 at N+2, tags in order.
- MULH a=0xFFFFFFFF (-1), b=0x00000002 → out=0xFFFFFFFF at N+33; busy high cycles N+1..N+32; in_ready=0 throughout; MUL same operands → 0xFFFFFFFE.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 at N+1; REM → 0; DIVU a=7, b=0 → 0xFFFFFFFF at N+1; REMU → 7.
- REM a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFF; DIV → 0xFFFFFFFD; MULHSU a=-1, b=0xFFFFFFFF → 0xFFFFFFFF.
- Backpressure: SUB 5-3 completes with out_ready=0 for 4 cycles → out=2 and out_tag held; in_ready=0; the next request accepted in the cycle out_ready rises.
- flush at cycle N+10 of a DIVU → out_valid never asserts for it, in_ready=1 at N+11; rst_n low mid-MUL → all outputs 0 next edge.
